// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular exponentiation engine and its
// Montgomery multiplier cores.
package rsa_pkg;

  localparam int RSA_WIDTH = 1024;

  // Montgomery "plain one": MontMul(A, ONE) converts A out of the Montgomery domain.
  localparam logic [RSA_WIDTH-1:0] ONE = {{(RSA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PRE_W,
    LOOP,
    LOOP_W,
    POST,
    POST_W
  } rsa_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_FIX,
    MM_WAIT
  } mm_state_e;

endpackage

// File: rtl/rsa_modexp_engine_mont.sv
// Bit-serial radix-2 Montgomery multiplier: res = a * b * 2^-WIDTH mod m.
// Operands are latched on start; done pulses once per start.
module rsa_modexp_engine_mont
  import rsa_pkg::*;
#(
  parameter int WIDTH      = 1024,
  parameter int DONE_DELAY = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] res,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DLY_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(DONE_DELAY);

  mm_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
  logic [WIDTH+1:0] t_q, t_d, sum_b, sum_m, t_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= MM_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      t_q     <= t_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MM_IDLE: if (start) state_d = MM_RUN;
      MM_RUN:  if (cnt_q == '0) state_d = MM_FIX;
      MM_FIX:  state_d = MM_WAIT;
      MM_WAIT: if (dly_q == '0) state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  // t stays below 2m with a, b < m, so two guard bits cover t + b + m < 4m.
  always_comb begin
    sum_b  = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    sum_m  = sum_b[0] ? (sum_b + {2'b00, m_q}) : sum_b;
    t_step = sum_m >> 1;
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    t_d    = t_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    dly_d  = dly_q;
    done   = 1'b0;
    case (state_q)
      MM_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          m_d   = m;
          t_d   = '0;
          cnt_d = CNT_LAST;
        end
      end
      MM_RUN: begin
        t_d   = t_step;
        a_d   = a_q >> 1;
        cnt_d = cnt_q - 1'b1;
      end
      MM_FIX: begin
        res_d = (t_q >= {2'b00, m_q}) ? WIDTH'(t_q - {2'b00, m_q}) : t_q[WIDTH-1:0];
        dly_d = DLY_INIT;
      end
      MM_WAIT: begin
        if (dly_q == '0) done = 1'b1;
        else dly_d = dly_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign res = res_q;

endmodule

// File: rtl/rsa_modexp_engine.sv
// Hardware-sequenced x^e mod n using right-to-left binary exponentiation with
// one Montgomery core on the accumulator (A) and one on the squared base (X_t).
//
// state  | meaning
// IDLE   | waiting for start; operands captured on accepted start
// PRE    | launch X_t = MontMul(x, R^2 mod n)
// PRE_W  | wait for X_t conversion
// LOOP   | launch square of X_t, and A*X_t when exponent bit i is set
// LOOP_W | wait for all launched cores, advance bit index
// POST   | launch A = MontMul(A, 1) to leave the Montgomery domain
// POST_W | wait, publish result, pulse done
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH        = 1024,
  parameter int EXP_WIDTH    = 32,
  parameter int LEN_W        = $clog2(EXP_WIDTH + 1),
  parameter int A_DONE_DELAY = 0,
  parameter int X_DONE_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     r2n,
  input  logic [WIDTH-1:0]     rn,
  input  logic [WIDTH-1:0]     n,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [LEN_W-1:0]     exp_len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result,
  output logic [31:0]          cycles
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(ONE);

  rsa_state_e state_q, state_d;

  logic [WIDTH-1:0]     x_q, r2n_q, rn_q, n_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [LEN_W-1:0]     len_q, i_q, i_inc;
  logic [WIDTH-1:0]     a_acc_q, xt_q, result_q;
  logic [31:0]          cycles_q;
  logic                 a_ok_q, x_ok_q, a_run_q, done_q, error_q;

  logic             mont_a_start, mont_x_start, mont_a_done, mont_x_done;
  logic [WIDTH-1:0] mont_a_op_a, mont_a_op_b, mont_x_op_a, mont_x_op_b;
  logic [WIDTH-1:0] mont_a_res, mont_x_res;
  logic             exp_bit, a_all, x_all, last_bit, len_bad;

  always_comb begin
    exp_bit = 1'b0;
    for (int k = 0; k < EXP_WIDTH; k++) begin
      if (i_q == LEN_W'(k)) exp_bit = exp_q[k];
    end
  end

  // A core that was not launched in this phase is pre-flagged at launch time.
  assign a_all    = a_ok_q | mont_a_done;
  assign x_all    = x_ok_q | mont_x_done;
  assign i_inc    = i_q + 1'b1;
  assign last_bit = (i_inc == len_q);
  assign len_bad  = (exp_len > LEN_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !len_bad) state_d = PRE;
      PRE:     state_d = PRE_W;
      PRE_W:   if (x_all) state_d = (len_q == '0) ? POST : LOOP;
      LOOP:    state_d = LOOP_W;
      LOOP_W:  if (a_all && x_all) state_d = last_bit ? POST : LOOP;
      POST:    state_d = POST_W;
      POST_W:  if (a_all) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both squaring and multiply read X_t/A before this phase's updates land.
  always_comb begin
    mont_a_start = 1'b0;
    mont_x_start = 1'b0;
    mont_a_op_a  = a_acc_q;
    mont_a_op_b  = xt_q;
    mont_x_op_a  = xt_q;
    mont_x_op_b  = xt_q;
    case (state_q)
      PRE: begin
        mont_x_start = 1'b1;
        mont_x_op_a  = x_q;
        mont_x_op_b  = r2n_q;
      end
      LOOP: begin
        mont_x_start = 1'b1;
        mont_a_start = exp_bit;
      end
      POST: begin
        mont_a_start = 1'b1;
        mont_a_op_b  = ONE_W;
      end
      default: ;
    endcase
    busy   = (state_q != IDLE);
    done   = done_q;
    error  = error_q;
    result = result_q;
    cycles = cycles_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q      <= '0;
      r2n_q    <= '0;
      rn_q     <= '0;
      n_q      <= '0;
      exp_q    <= '0;
      len_q    <= '0;
      i_q      <= '0;
      a_acc_q  <= '0;
      xt_q     <= '0;
      result_q <= '0;
      cycles_q <= '0;
      a_ok_q   <= 1'b0;
      x_ok_q   <= 1'b0;
      a_run_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start && len_bad) begin
          error_q <= 1'b1;
        end else if (start) begin
          x_q      <= x;
          r2n_q    <= r2n;
          rn_q     <= rn;
          n_q      <= n;
          exp_q    <= exponent;
          len_q    <= exp_len;
          a_acc_q  <= rn;
          i_q      <= '0;
          cycles_q <= '0;
        end
      end else if (cycles_q != '1) begin
        cycles_q <= cycles_q + 1'b1;
      end

      if (mont_a_start || mont_x_start) begin
        a_ok_q  <= !mont_a_start;
        x_ok_q  <= !mont_x_start;
        a_run_q <= mont_a_start;
      end else begin
        if (mont_a_done) a_ok_q <= 1'b1;
        if (mont_x_done) x_ok_q <= 1'b1;
      end

      if (mont_a_done && a_run_q) begin
        a_acc_q <= mont_a_res;
        a_run_q <= 1'b0;
      end
      if (mont_x_done) xt_q <= mont_x_res;

      if (state_q == LOOP_W && a_all && x_all) i_q <= i_inc;

      if (state_q == POST_W && a_all) begin
        result_q <= mont_a_res;
        done_q   <= 1'b1;
      end
    end
  end

  rsa_modexp_engine_mont #(
    .WIDTH      (WIDTH),
    .DONE_DELAY (A_DONE_DELAY)
  ) mont_a (
    .clk    (clk),
    .resetn (resetn),
    .start  (mont_a_start),
    .a      (mont_a_op_a),
    .b      (mont_a_op_b),
    .m      (n_q),
    .res    (mont_a_res),
    .done   (mont_a_done)
  );

  rsa_modexp_engine_mont #(
    .WIDTH      (WIDTH),
    .DONE_DELAY (X_DONE_DELAY)
  ) mont_x (
    .clk    (clk),
    .resetn (resetn),
    .start  (mont_x_start),
    .a      (mont_x_op_a),
    .b      (mont_x_op_b),
    .m      (n_q),
    .res    (mont_x_res),
    .done   (mont_x_done)
  );

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine: three instances with core done skews of 0, 1 and 5
// cycles share stimulus and are compared against a plain modular-power model.
module tb_rsa_modexp_engine;
  import rsa_pkg::*;

  localparam int WIDTH     = 1024;
  localparam int EXP_WIDTH = 32;
  localparam int LEN_W     = $clog2(EXP_WIDTH + 1);
  localparam int NDUT      = 3;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     x = '0;
  logic [WIDTH-1:0]     r2n = '0;
  logic [WIDTH-1:0]     rn = '0;
  logic [WIDTH-1:0]     n = '0;
  logic [EXP_WIDTH-1:0] exponent = '0;
  logic [LEN_W-1:0]     exp_len = '0;

  logic [NDUT-1:0]      busy_v, done_v, error_v;
  logic [WIDTH-1:0]     result_v [NDUT];
  logic [31:0]          cycles_v [NDUT];

  int checks = 0;
  int failures = 0;
  int na_cnt = 0;
  int nx_cnt = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    rsa_modexp_engine #(
      .WIDTH        (WIDTH),
      .EXP_WIDTH    (EXP_WIDTH),
      .A_DONE_DELAY ((k == 1) ? 1 : 0),
      .X_DONE_DELAY ((k == 2) ? 5 : 0)
    ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .x        (x),
      .r2n      (r2n),
      .rn       (rn),
      .n        (n),
      .exponent (exponent),
      .exp_len  (exp_len),
      .busy     (busy_v[k]),
      .done     (done_v[k]),
      .error    (error_v[k]),
      .result   (result_v[k]),
      .cycles   (cycles_v[k])
    );
  end

  always @(posedge clk) begin
    if (g_dut[0].dut.mont_a.start) na_cnt <= na_cnt + 1;
    if (g_dut[0].dut.mont_x.start) nx_cnt <= nx_cnt + 1;
  end

  function automatic longint mod_r(input longint nv);
    longint r;
    r = 1 % nv;
    for (int k = 0; k < WIDTH; k++) r = (r * 2) % nv;
    return r;
  endfunction

  function automatic longint ref_pow(input longint xv, input longint ev, input longint nv);
    longint r;
    r = 1 % nv;
    for (longint k = 0; k < ev; k++) r = (r * xv) % nv;
    return r;
  endfunction

  task automatic set_inputs(input longint xv, input longint nv, input logic [31:0] ev, input int lenv);
    longint r;
    r = mod_r(nv);
    x = '0;   x[63:0] = xv;
    n = '0;   n[63:0] = nv;
    rn = '0;  rn[63:0] = r;
    r2n = '0; r2n[63:0] = (r * r) % nv;
    exponent = ev;
    exp_len = LEN_W'(lenv);
  endtask

  task automatic run_job(input string name, input longint xv, input longint nv,
                         input logic [31:0] ev, input int lenv, input int poke);
    longint e_eff, expv;
    logic [WIDTH-1:0] exp_w;
    int na0, nx0, cyc, err_seen, exp_na, exp_nx;
    int busy_cnt [NDUT];
    int done_cnt [NDUT];
    bit fin [NDUT];
    bit drop [NDUT];
    bit all_fin;
    e_eff = longint'(ev) & ((longint'(1) << lenv) - 1);
    expv = ref_pow(xv, e_eff, nv);
    exp_w = '0;
    exp_w[63:0] = expv;
    exp_na = $countones(e_eff) + 1;
    exp_nx = lenv + 1;
    for (int k = 0; k < NDUT; k++) begin
      busy_cnt[k] = 0; done_cnt[k] = 0; fin[k] = 1'b0; drop[k] = 1'b0;
    end
    set_inputs(xv, nv, ev, lenv);
    @(negedge clk);
    na0 = na_cnt;
    nx0 = nx_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    err_seen = 0;
    all_fin = 1'b0;
    while (!all_fin && cyc < 20000) begin
      all_fin = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
        if (error_v[k]) err_seen++;
        if (done_v[k]) begin
          done_cnt[k]++;
          fin[k] = 1'b1;
        end else if (!fin[k]) begin
          if (busy_v[k]) busy_cnt[k]++;
          else drop[k] = 1'b1;
        end
        if (!fin[k]) all_fin = 1'b0;
      end
      if (poke > 0 && cyc == poke) begin
        start = 1'b1;
        x = '0;
        x[15:0] = 16'hbeef;
        exponent = ~exponent;
        exp_len = LEN_W'(40);
      end
      if (poke > 0 && cyc == poke + 1) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (done_v[k]) done_cnt[k]++;
        if (error_v[k]) err_seen++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (fin[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s_timeout dut%0d got=no_done exp=done", name, k);
      end
      checks++;
      if (done_cnt[k] !== 1) begin
        failures++;
        $display("FAIL %s_done_pulses dut%0d got=%0d exp=1", name, k, done_cnt[k]);
      end
      checks++;
      if (drop[k] !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_gap dut%0d got=busy_low_before_done exp=busy_high", name, k);
      end
      checks++;
      if (result_v[k] !== exp_w) begin
        failures++;
        $display("FAIL %s_result dut%0d got=%0h exp=%0h", name, k, result_v[k][63:0], expv);
      end
      checks++;
      if (cycles_v[k] !== 32'(busy_cnt[k])) begin
        failures++;
        $display("FAIL %s_cycles dut%0d got=%0d exp=%0d", name, k, cycles_v[k], busy_cnt[k]);
      end
    end
    checks++;
    if (err_seen !== 0) begin
      failures++;
      $display("FAIL %s_error got=%0d exp=0", name, err_seen);
    end
    checks++;
    if ((na_cnt - na0) !== exp_na) begin
      failures++;
      $display("FAIL %s_a_starts got=%0d exp=%0d", name, na_cnt - na0, exp_na);
    end
    checks++;
    if ((nx_cnt - nx0) !== exp_nx) begin
      failures++;
      $display("FAIL %s_x_starts got=%0d exp=%0d", name, nx_cnt - nx0, exp_nx);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if ({busy_v[k], done_v[k], error_v[k]} !== 3'b000) begin
        failures++;
        $display("FAIL %s_flags dut%0d got=%b exp=000", name, k, {busy_v[k], done_v[k], error_v[k]});
      end
      checks++;
      if (result_v[k] !== '0) begin
        failures++;
        $display("FAIL %s_result dut%0d got=%0h exp=0", name, k, result_v[k][63:0]);
      end
      checks++;
      if (cycles_v[k] !== 32'd0) begin
        failures++;
        $display("FAIL %s_cycles dut%0d got=%0d exp=0", name, k, cycles_v[k]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job("basic", 5, 29, 32'd3, 2, 0);
  endtask

  task automatic test_multi_bit();
    run_job("multi", 2, 59, 32'hB, 4, 0);
  endtask

  task automatic test_leading_zeros();
    run_job("lead0", 7, 29, 32'd1, 4, 0);
  endtask

  task automatic test_exp_zero();
    run_job("exp0", longint'($urandom_range(58, 0)), 59, $urandom, 0, 0);
  endtask

  task automatic test_error();
    logic [WIDTH-1:0] prev [NDUT];
    int err_cnt [NDUT];
    int busy_seen, done_seen;
    for (int k = 0; k < NDUT; k++) begin
      prev[k] = result_v[k];
      err_cnt[k] = 0;
    end
    busy_seen = 0;
    done_seen = 0;
    exp_len = LEN_W'(33);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (error_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL err_first_cycle got=%b exp=1", error_v[0]);
    end
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (error_v[k]) err_cnt[k]++;
        if (busy_v[k]) busy_seen++;
        if (done_v[k]) done_seen++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (err_cnt[k] !== 1) begin
        failures++;
        $display("FAIL err_pulses dut%0d got=%0d exp=1", k, err_cnt[k]);
      end
      checks++;
      if (result_v[k] !== prev[k]) begin
        failures++;
        $display("FAIL err_result_held dut%0d got=%0h exp=%0h", k, result_v[k][63:0], prev[k][63:0]);
      end
    end
    checks++;
    if (busy_seen !== 0 || done_seen !== 0) begin
      failures++;
      $display("FAIL err_busy_done got=busy%0d_done%0d exp=busy0_done0", busy_seen, done_seen);
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b_poke", 2, 59, 32'hB, 4, 50);
    run_job("b2b_next", 5, 29, 32'd3, 2, 0);
  endtask

  task automatic test_abort();
    int cyc, done_seen;
    set_inputs(5, 29, 32'd3, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    done_seen = 0;
    while (g_dut[0].dut.state_q != LOOP_W && cyc < 5000) begin
      if (done_v != '0) done_seen++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (g_dut[0].dut.state_q != LOOP_W) begin
      failures++;
      $display("FAIL abort_reach_loop_w got=%0d exp=%0d", g_dut[0].dut.state_q, LOOP_W);
    end
    repeat (20) begin
      if (done_v != '0) done_seen++;
      @(negedge clk);
    end
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_v != '0) done_seen++;
    end
    check_reset_outputs("abort");
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done_v != '0) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    end
    run_job("abort_rerun", 5, 29, 32'd3, 2, 0);
  endtask

  task automatic test_random();
    longint nv, xv;
    for (int j = 0; j < 3; j++) begin
      nv = longint'($urandom_range(65535, 3)) | 1;
      xv = longint'($urandom_range(int'(nv - 1), 0));
      run_job("random", xv, nv, $urandom, int'($urandom_range(5, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_bit();
    test_leading_zeros();
    test_exp_zero();
    test_error();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
